// File: rtl/fp32_mul_arb.sv
// fp32_mul_arb: round-robin arbiter that shares one pipelined FP32 multiplier
// among N_REQ requesters. Each issue pushes its requester index onto an
// in-order tag FIFO. Each multiplier result pops a tag and is returned to the
// requester that issued it.
// Optional feature: define FP32_MUL_ARB_STATS_EN to add the stat_issue and
// stat_stall counters.
module fp32_mul_arb #(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_y,
    output logic                  mul_valid,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic                  mul_ready,
    input  logic [31:0]           mul_y,
    output logic                  busy,
    output logic                  err_unexp
`ifdef FP32_MUL_ARB_STATS_EN
    ,
    output logic [31:0]           stat_issue,
    output logic [31:0]           stat_stall
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [IDX_W-1:0] r_tag_mem [MAX_OUT];
    logic             r_mul_valid;
    logic [31:0]      r_mul_a;
    logic [31:0]      r_mul_b;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [31:0]      r_rsp_y;
    logic             r_err;

    logic [31:0]      w_a [N_REQ];
    logic [31:0]      w_b [N_REQ];
    logic             w_full;
    logic             w_issue;
    logic             w_pop;
    logic             w_drop;
    logic [N_REQ-1:0] w_gnt;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_pop_tag;
    int               w_cand;

    // Unpack the flat operand buses into per-requester words.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_a[gi] = req_a[32*gi +: 32];
        assign w_b[gi] = req_b[32*gi +: 32];
    end

    // A full FIFO blocks grants even if a pop happens in the same cycle.
    // The freed slot can be used on the following cycle.
    assign w_full    = (r_cnt == CNT_W'(MAX_OUT));
    assign w_pop     = mul_ready && (r_cnt != '0);
    assign w_drop    = mul_ready && (r_cnt == '0);
    assign w_pop_tag = r_tag_mem[r_rd_ptr];

    // Round-robin search. It starts at r_rr_ptr and wraps modulo N_REQ.
    // The first active request found wins the grant.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_issue   = 1'b0;
        w_cand    = 0;
        if (rstn && !w_full) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_cand = int'(r_rr_ptr) + k;
                if (w_cand >= N_REQ) begin
                    w_cand = w_cand - N_REQ;
                end
                if (!w_issue && req[w_cand]) begin
                    w_issue        = 1'b1;
                    w_gnt[w_cand]  = 1'b1;
                    w_gnt_idx      = IDX_W'(w_cand);
                end
            end
        end
    end

    // Update the round-robin pointer, the outstanding count and the FIFO pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr <= (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_issue && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_issue && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Tag storage. The FIFO is emptied through its pointers, so the
    // storage array itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_mem[r_wr_ptr] <= w_gnt_idx;
        end
    end

    // Issue register. Operands are held between issues.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mul_valid <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_mul_valid <= w_issue;
            if (w_issue) begin
                r_mul_a <= w_a[w_gnt_idx];
                r_mul_b <= w_b[w_gnt_idx];
            end
        end
    end

    // Response register. A result that arrives with no tag outstanding is
    // dropped and raises the sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid <= '0;
            r_rsp_y     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= w_pop ? (N_REQ'(1) << w_pop_tag) : '0;
            if (w_pop) begin
                r_rsp_y <= mul_y;
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef FP32_MUL_ARB_STATS_EN
    logic [31:0] r_stat_issue;
    logic [31:0] r_stat_stall;

    // Count issues, and count cycles where a request is stalled because the FIFO is full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_issue <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_issue) begin
                r_stat_issue <= r_stat_issue + 32'd1;
            end
            if ((req != '0) && w_full) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_issue = r_stat_issue;
    assign stat_stall = r_stat_stall;
`endif

    assign gnt       = w_gnt;
    assign mul_valid = r_mul_valid;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign busy      = (r_cnt != '0);
    assign err_unexp = r_err;

endmodule
